// File: rtl/user_joy_pkg.sv
// Shared types and constants for the DB15 user-port joystick serial reader.
// Contents: FSM state enum, decoded-word bit positions, frame width and the
// helper that turns a raw active-low 32-bit frame into the 24 decoded bits.
package user_joy_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    IDLE   = 2'd3
  } user_joy_state_t;

  // Bit positions inside joystick1/joystick2 (FEDCBAUDLR plus S/M).
  localparam int unsigned JOY_R = 0;
  localparam int unsigned JOY_L = 1;
  localparam int unsigned JOY_D = 2;
  localparam int unsigned JOY_U = 3;
  localparam int unsigned JOY_A = 4;
  localparam int unsigned JOY_B = 5;
  localparam int unsigned JOY_C = 6;
  localparam int unsigned JOY_D_BTN = 7;
  localparam int unsigned JOY_E = 8;
  localparam int unsigned JOY_F = 9;
  localparam int unsigned JOY_S = 10;
  localparam int unsigned JOY_M = 11;

  localparam int unsigned FRAME_BITS = 32;

  // {player1[11:0], player2[11:0]}, active-high; nibbles [31:28]/[15:12] dropped.
  function automatic logic [23:0] decode_frame(input logic [FRAME_BITS-1:0] raw);
    return {~raw[27:16], ~raw[11:0]};
  endfunction

endpackage

// File: rtl/user_joy_tick.sv
// Serial half-period prescaler for the user-port joystick reader.
// Ports:
//   clk   - joystick clock
//   reset - asynchronous, active-high; count returns to 0
//   en    - count enable (held low for one cycle while a frame is published)
//   tick  - one-cycle pulse when the count reaches CLK_DIV-1
module user_joy_tick #(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/user_joy_serial.sv
// Serial reader for the DB15 user-port joystick adapter (74HC165 chain).
// Drives the shift/load lines, shifts in 32 bits MSB-first per frame and
// publishes two decoded active-high 16-bit joystick words.
// Ports:
//   clk          - joystick clock (40-50 MHz)
//   reset        - asynchronous, active-high
//   joy_data     - serial data from adapter, async, active-low buttons
//   joy_clk      - 74HC165 shift clock
//   joy_load     - 74HC165 parallel load, active-low
//   joystick1/2  - decoded words, bits [11:0] = MSCBA..UDLR style FEDCBAUDLR, bit 0 = right
//   frame_strobe - one-cycle pulse when joystick1/2 update
// Optional feature macro: USER_JOY_AGREE_EN -- publish a frame only when it
// matches the previous frame (glitch filter for loose connectors).
module user_joy_serial
  import user_joy_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 6,
  parameter int unsigned IDLE_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe
);

  if (CLK_DIV < 3 || IDLE_TICKS < 1) begin : g_bad_params
    $error("user_joy_serial: CLK_DIV must be >= 3 and IDLE_TICKS >= 1");
  end

  localparam int unsigned IW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  user_joy_state_t         state, state_next;
  logic [1:0]              sync;
  logic                    phase, phase_n;
  logic [4:0]              bit_cnt, bit_cnt_n;
  logic [IW-1:0]           idle_cnt, idle_cnt_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic                    joy_clk_n, joy_load_n, strobe_n;
  logic [15:0]             j1_n, j2_n;
  logic [23:0]             decoded;
  logic                    tick;
`ifdef USER_JOY_AGREE_EN
  logic [23:0]             prev, prev_n;
`endif

  // The prescaler pauses during the single UPDATE cycle, so a frame lasts
  // (2 + 64 + IDLE_TICKS) * CLK_DIV + 1 cycles.
  user_joy_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (state != UPDATE),
    .tick (tick)
  );

  assign decoded = decode_frame(shreg);

  always_comb begin
    state_next = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    idle_cnt_n = idle_cnt;
    shreg_n    = shreg;
    joy_clk_n  = joy_clk;
    joy_load_n = joy_load;
    j1_n       = joystick1;
    j2_n       = joystick2;
    strobe_n   = 1'b0;
`ifdef USER_JOY_AGREE_EN
    prev_n     = prev;
`endif
    case (state)
      LOAD: begin
        if (tick) begin
          joy_clk_n = 1'b1;
          if (!phase) begin
            joy_load_n = 1'b0;
            phase_n    = 1'b1;
          end else begin
            joy_load_n = 1'b1;
            phase_n    = 1'b0;
            bit_cnt_n  = '0;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase) begin
            joy_clk_n = 1'b0;
            phase_n   = 1'b1;
          end else begin
            // Sample on the tick that raises joy_clk: the synced value is the
            // pin as it was mid low half-period.
            shreg_n   = {shreg[FRAME_BITS-2:0], sync[1]};
            joy_clk_n = 1'b1;
            phase_n   = 1'b0;
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) state_next = UPDATE;
          end
        end
      end
      UPDATE: begin
`ifdef USER_JOY_AGREE_EN
        prev_n = decoded;
        if (decoded == prev) begin
          j1_n     = {4'b0000, decoded[23:12]};
          j2_n     = {4'b0000, decoded[11:0]};
          strobe_n = 1'b1;
        end
`else
        j1_n     = {4'b0000, decoded[23:12]};
        j2_n     = {4'b0000, decoded[11:0]};
        strobe_n = 1'b1;
`endif
        idle_cnt_n = '0;
        state_next = IDLE;
      end
      IDLE: begin
        joy_clk_n  = 1'b1;
        joy_load_n = 1'b1;
        if (tick) begin
          if (idle_cnt == IW'(IDLE_TICKS - 1)) begin
            idle_cnt_n = '0;
            state_next = LOAD;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      sync         <= '0;
      phase        <= 1'b0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      shreg        <= '0;
      joy_clk      <= 1'b1;
      joy_load     <= 1'b1;
      joystick1    <= '0;
      joystick2    <= '0;
      frame_strobe <= 1'b0;
`ifdef USER_JOY_AGREE_EN
      prev         <= '0;
`endif
    end else begin
      state        <= state_next;
      sync         <= {sync[0], joy_data};
      phase        <= phase_n;
      bit_cnt      <= bit_cnt_n;
      idle_cnt     <= idle_cnt_n;
      shreg        <= shreg_n;
      joy_clk      <= joy_clk_n;
      joy_load     <= joy_load_n;
      joystick1    <= j1_n;
      joystick2    <= j2_n;
      frame_strobe <= strobe_n;
`ifdef USER_JOY_AGREE_EN
      prev         <= prev_n;
`endif
    end
  end

endmodule
